// File: rtl/mips_exc_pkg.sv
// Shared state encoding, exception-request codes and default vectors for the exception/ERET redirect unit.
package mips_exc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    REDIRECT
  } exc_state_e;

  localparam logic [1:0]  EXC_NONE   = 2'd0;
  localparam logic [1:0]  EXC_NORMAL = 2'd1;
  localparam logic [1:0]  EXC_DS     = 2'd2;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
  localparam logic [7:0]  DRAIN_MAX_DEFAULT  = 8'd255;

endpackage

// File: rtl/exc_drain_timer.sv
// Drain watchdog: 8-bit counter cleared on drain entry, counts drain cycles, saturates at DRAIN_MAX.
// expired is combinational and flags the drain cycle on which the count reaches DRAIN_MAX.
module exc_drain_timer
  import mips_exc_pkg::*;
#(
  parameter logic [7:0] DRAIN_MAX = DRAIN_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc && (cnt_q != DRAIN_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Comparing the post-increment value makes the wait exactly DRAIN_MAX drain cycles.
  assign expired = inc && (cnt_d == DRAIN_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exc_redirect.sv
// Exception/ERET redirect: flush one cycle after the request, redirect offered the next cycle and held until fetch_ready;
// stall_req holds upstream while busy. Define EXC_DRAIN_EN to wait (bounded) for data-side AXI to drain before flushing.
module exc_redirect
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [7:0]  DRAIN_MAX  = DRAIN_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  exc,
  input  logic        back,
  input  logic [31:0] epc,
  input  logic        pause,
  input  logic [3:0]  mem_outstanding,
  input  logic        fetch_ready,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        flush_mem,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        stall_req,
  output logic        drain_timeout
);

  exc_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        is_exc, req, drain_done;

  assign is_exc = (exc == EXC_NORMAL) || (exc == EXC_DS);
  assign req    = (state_q == IDLE) && !pause && (is_exc || back);

`ifdef EXC_DRAIN_EN
  localparam exc_state_e AFTER_REQ = DRAIN;

  logic drain_expired, timeout_q, timeout_d;

  exc_drain_timer #(
    .DRAIN_MAX(DRAIN_MAX)
  ) u_drain_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (req),
    .inc    (state_q == DRAIN),
    .expired(drain_expired)
  );

  assign drain_done = (mem_outstanding == 4'd0) || drain_expired;

  // A clean drain on the last allowed cycle is not a timeout.
  always_comb begin
    timeout_d = timeout_q | ((state_q == DRAIN) && (mem_outstanding != 4'd0) && drain_expired);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign drain_timeout = timeout_q;
`else
  localparam exc_state_e AFTER_REQ = FLUSH;

  logic unused_drain;
  assign unused_drain  = ^{mem_outstanding, DRAIN_MAX};
  assign drain_done    = 1'b1;
  assign drain_timeout = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_mem      = 1'b0;
    redirect_valid = 1'b0;
    stall_req      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (req) begin
          // An exception outranks a same-cycle ERET; the ERET is simply dropped.
          pc_d    = is_exc ? EXC_VECTOR : epc;
          state_d = AFTER_REQ;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        flush_mem = 1'b1;
        state_d   = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (fetch_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign redirect_pc = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_exc_redirect.sv
// Bench for exc_redirect: directed latency/drain/reset sequences, a vector table, and randomized traffic vs a timeline model.
module tb_exc_redirect;

  localparam logic [31:0] VEC = 32'hBFC00380;
`ifdef EXC_DRAIN_EN
  localparam int DL       = 1;
  localparam bit DRAIN_ON = 1'b1;
`else
  localparam int DL       = 0;
  localparam bit DRAIN_ON = 1'b0;
`endif
  localparam int FAR = 1 << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  exc;
  logic        back;
  logic [31:0] epc;
  logic        pause;
  logic [3:0]  mem_outstanding;
  logic        fetch_ready;
  logic        flush_if, flush_id, flush_ex, flush_mem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_req;
  logic        drain_timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exc_redirect dut (
    .clk            (clk),
    .rst            (rst),
    .exc            (exc),
    .back           (back),
    .epc            (epc),
    .pause          (pause),
    .mem_outstanding(mem_outstanding),
    .fetch_ready    (fetch_ready),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .flush_mem      (flush_mem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_req      (stall_req),
    .drain_timeout  (drain_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flushes();
    return {flush_if, flush_id, flush_ex, flush_mem};
  endfunction

  // Timeline model: an accepted request schedules a flush cycle and a redirect window.
  bit          m_busy = 1'b0, m_in_drain = 1'b0, m_timeout = 1'b0;
  int          m_flush_at = FAR, m_valid_from = FAR, m_dcnt = 0;
  logic [31:0] m_pc = 32'd0;

  always @(negedge clk) begin
    bit e_flush, e_valid;
    e_flush = m_busy && (cyc == m_flush_at);
    e_valid = m_busy && !m_in_drain && (cyc >= m_valid_from);
    chk("model", {flushes(), redirect_valid, stall_req, drain_timeout, redirect_pc},
        {{4{e_flush}}, e_valid, m_busy, m_timeout, m_pc});
    if (rst) begin
      m_busy = 0; m_in_drain = 0; m_timeout = 0; m_pc = 32'd0;
      m_flush_at = FAR; m_valid_from = FAR;
    end else if (!m_busy) begin
      if (!pause && (exc == 2'd1 || exc == 2'd2 || back)) begin
        m_busy = 1;
        m_pc   = (exc == 2'd1 || exc == 2'd2) ? VEC : epc;
        if (DRAIN_ON) begin
          m_in_drain = 1; m_dcnt = 0; m_flush_at = FAR; m_valid_from = FAR;
        end else begin
          m_flush_at = cyc + 1; m_valid_from = cyc + 2;
        end
      end
    end else if (m_in_drain) begin
      m_dcnt++;
      if (mem_outstanding == 0 || m_dcnt >= 255) begin
        if (mem_outstanding != 0) m_timeout = 1;
        m_in_drain = 0; m_flush_at = cyc + 1; m_valid_from = cyc + 2;
      end
    end else if (e_valid && fetch_ready) begin
      m_busy = 0; m_flush_at = FAR; m_valid_from = FAR;
    end
  end

  typedef struct {
    logic [1:0]  exc;
    logic        back;
    logic [31:0] epc;
    logic        pause;
    int          delay;
    logic        acc;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[9];

  task automatic run_row(input int i);
    vec_t r;
    r = tbl[i];
    tick();
    exc = r.exc; back = r.back; epc = r.epc; pause = r.pause; fetch_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("row%0d_req_idle", i), stall_req, 1'b0);
    tick();
    exc = 2'd0; back = 1'b0; pause = 1'b0; epc = $urandom;
    for (int k = 0; k < DL; k++) begin
      @(negedge clk);
      chk($sformatf("row%0d_drain", i), {flushes(), stall_req}, {4'h0, r.acc});
      tick();
    end
    @(negedge clk);
    chk($sformatf("row%0d_flush", i), {flushes(), stall_req}, {r.acc ? 4'hF : 4'h0, r.acc});
    tick();
    if (r.acc) begin
      for (int k = 0; k <= r.delay; k++) begin
        fetch_ready = (k == r.delay);
        epc = $urandom;
        @(negedge clk);
        chk($sformatf("row%0d_valid", i), {redirect_valid, flushes()}, {1'b1, 4'h0});
        chk($sformatf("row%0d_pc", i), redirect_pc, r.pc);
        tick();
      end
      fetch_ready = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("row%0d_idle", i), {redirect_valid, stall_req, flushes()}, 6'd0);
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd1, 1'b0, 32'h0000_0000, 1'b0, 0, 1'b1, VEC};
    tbl[1] = '{2'd2, 1'b1, 32'h0000_1234, 1'b0, 0, 1'b1, VEC};
    tbl[2] = '{2'd0, 1'b1, 32'h8000_1234, 1'b0, 3, 1'b1, 32'h8000_1234};
    tbl[3] = '{2'd3, 1'b0, 32'h1111_1111, 1'b0, 0, 1'b0, 32'h0};
    tbl[4] = '{2'd1, 1'b0, 32'h2222_2222, 1'b1, 0, 1'b0, 32'h0};
    tbl[5] = '{2'd3, 1'b1, 32'h9ABC_DEF0, 1'b0, 1, 1'b1, 32'h9ABC_DEF0};
    tbl[6] = '{2'd0, 1'b0, 32'h3333_3333, 1'b0, 0, 1'b0, 32'h0};
    tbl[7] = '{2'd0, 1'b1, 32'h4444_4444, 1'b1, 0, 1'b0, 32'h0};
    tbl[8] = '{2'd2, 1'b0, 32'h5555_5555, 1'b0, 2, 1'b1, VEC};

    rst = 1'b1; exc = 2'd0; back = 1'b0; epc = 32'd0; pause = 1'b0;
    mem_outstanding = 4'd0; fetch_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {flushes(), redirect_valid, stall_req, drain_timeout, redirect_pc}, 39'd0);

    // exc=1 at cycle 10 with fetch_ready high
    while (cyc < 10) tick();
    exc = 2'd1; fetch_ready = 1'b1;
    @(negedge clk);
    chk("c10_idle", stall_req, 1'b0);
    tick();
    exc = 2'd0;
    for (int k = 0; k < DL; k++) begin
      @(negedge clk); chk("c10_drain", flushes(), 4'h0); tick();
    end
    @(negedge clk);
    chk("c11_flush", {flushes(), redirect_valid}, {4'hF, 1'b0});
    tick();
    @(negedge clk);
    chk("c12_valid", {redirect_valid, flushes()}, {1'b1, 4'h0});
    chk("c12_pc", redirect_pc, VEC);
    tick();
    @(negedge clk);
    chk("c13_idle", {redirect_valid, stall_req}, 2'b00);
    tick();
    fetch_ready = 1'b0;

    for (int i = 0; i < 9; i++) run_row(i);

`ifdef EXC_DRAIN_EN
    // outstanding traffic drains after five cycles
    mem_outstanding = 4'd3; exc = 2'd1; fetch_ready = 1'b1;
    tick();
    exc = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      mem_outstanding = (k <= 5) ? 4'd3 : 4'd0;
      @(negedge clk);
      chk("drain3_wait", {flushes(), stall_req}, {4'h0, 1'b1});
      tick();
    end
    @(negedge clk);
    chk("drain3_flush", {flushes(), drain_timeout}, {4'hF, 1'b0});
    tick();
    @(negedge clk);
    chk("drain3_valid", redirect_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("drain3_idle", {stall_req, drain_timeout}, 2'b00);
    tick();

    // stuck traffic: timeout after 255 drain cycles
    mem_outstanding = 4'd1; exc = 2'd1;
    tick();
    exc = 2'd0;
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      chk("stuck_wait", {flushes(), stall_req, drain_timeout}, {4'h0, 1'b1, 1'b0});
      tick();
    end
    @(negedge clk);
    chk("stuck_flush", {flushes(), drain_timeout}, {4'hF, 1'b1});
    tick();
    mem_outstanding = 4'd0;
    repeat (3) tick();
    back = 1'b1; epc = 32'h0000_0040;
    tick();
    back = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("timeout_sticky", {drain_timeout, stall_req}, 2'b10);
    tick();
    fetch_ready = 1'b0;
`endif

    // reset in the middle of a pending handshake
    exc = 2'd1; fetch_ready = 1'b0;
    tick();
    exc = 2'd0;
    repeat (DL + 2) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_redirect_valid", redirect_valid, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {flushes(), redirect_valid, stall_req, drain_timeout, redirect_pc}, 39'd0);
    tick();
    exc = 2'd1; fetch_ready = 1'b1;
    tick();
    exc = 2'd0;
    repeat (DL) tick();
    @(negedge clk);
    chk("post_rst_flush", flushes(), 4'hF);
    tick();
    @(negedge clk);
    chk("post_rst_pc", {redirect_valid, redirect_pc}, {1'b1, VEC});
    tick();

    for (int i = 0; i < 3000; i++) begin
      exc             = 2'($urandom_range(0, 3));
      back            = ($urandom_range(0, 3) == 0);
      pause           = ($urandom_range(0, 3) == 0);
      epc             = $urandom;
      fetch_ready     = ($urandom_range(0, 1) == 1);
      mem_outstanding = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      rst             = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; exc = 2'd0; back = 1'b0; fetch_ready = 1'b1; mem_outstanding = 4'd0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
